// File: rtl/vga_sync_porch.sv
// VGA sync/porch stage: turns upstream active-region flags into negative-polarity
// HSync/VSync pulses, blanks pixel data and reports upstream frame-period lock.
module vga_sync_porch #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_BACK_PORCH  = 33,
  parameter int VIDEO_WIDTH   = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [VIDEO_WIDTH-1:0] i_Red,
  input  logic [VIDEO_WIDTH-1:0] i_Grn,
  input  logic [VIDEO_WIDTH-1:0] i_Blu,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red,
  output logic [VIDEO_WIDTH-1:0] o_Grn,
  output logic [VIDEO_WIDTH-1:0] o_Blu,
  output logic                   o_Locked
);

  localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] HS_START = 10'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [9:0] HS_END   = 10'(TOTAL_COLS - H_BACK_PORCH - 1);
  localparam logic [9:0] VS_START = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [9:0] VS_END   = 10'(TOTAL_ROWS - V_BACK_PORCH - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  logic                   hsync_p1, vsync_p1;
  logic [VIDEO_WIDTH-1:0] red_p1, grn_p1, blu_p1;
  logic [9:0]             col_p1, row_p1;
  logic                   vsync_seen_low;
  logic                   fs, fs_expected;
  logic                   video_en, locked_nxt;
  state_t                 state, state_nxt;

  // vsync_p1 resets low, so a rising edge only counts once i_VSync has been
  // observed low; this keeps a reset released mid-active-area from faking FS.
  assign fs          = i_VSync & ~vsync_p1 & vsync_seen_low;
  assign fs_expected = (col_p1 == COL_LAST) && (row_p1 == ROW_LAST);

  // ---- stage 1: input capture and position counters ----
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hsync_p1       <= 1'b0;
      vsync_p1       <= 1'b0;
      red_p1         <= '0;
      grn_p1         <= '0;
      blu_p1         <= '0;
      col_p1         <= '0;
      row_p1         <= '0;
      vsync_seen_low <= 1'b0;
    end else begin
      hsync_p1       <= i_HSync;
      vsync_p1       <= i_VSync;
      red_p1         <= i_Red;
      grn_p1         <= i_Grn;
      blu_p1         <= i_Blu;
      vsync_seen_low <= vsync_seen_low | ~i_VSync;
      if (fs) begin
        col_p1 <= '0;
        row_p1 <= '0;
      end else if (col_p1 == COL_LAST) begin
        col_p1 <= '0;
        row_p1 <= (row_p1 == ROW_LAST) ? 10'd0 : row_p1 + 10'd1;
      end else begin
        col_p1 <= col_p1 + 10'd1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= ST_UNLOCKED;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (fs) begin
      case (state)
        ST_UNLOCKED: state_nxt = ST_ACQUIRE;
        ST_ACQUIRE:  state_nxt = fs_expected ? ST_LOCKED : ST_ACQUIRE;
        ST_LOCKED:   state_nxt = fs_expected ? ST_LOCKED : ST_ACQUIRE;
        default:     state_nxt = ST_UNLOCKED;
      endcase
    end
  end

  always_comb begin
    locked_nxt = (state == ST_LOCKED);
    video_en   = hsync_p1 & vsync_p1 & (state == ST_LOCKED);
  end

  // ---- stage 2: sync pulses, blanking, lock flag ----
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_HSync  <= 1'b1;
      o_VSync  <= 1'b1;
      o_Red    <= '0;
      o_Grn    <= '0;
      o_Blu    <= '0;
      o_Locked <= 1'b0;
    end else begin
      o_HSync  <= ~in_range(col_p1, HS_START, HS_END);
      o_VSync  <= ~in_range(row_p1, VS_START, VS_END);
      o_Red    <= video_en ? red_p1 : '0;
      o_Grn    <= video_en ? grn_p1 : '0;
      o_Blu    <= video_en ? blu_p1 : '0;
      o_Locked <= locked_nxt;
    end
  end

endmodule

// File: tb/tb_vga_sync_porch.sv
// Scoreboard bench for vga_sync_porch on a reduced 20x10 raster so that
// several frames, a phase error and a mid-frame reset fit in a short run.
module tb_vga_sync_porch;

  localparam int TC  = 20;
  localparam int TR  = 10;
  localparam int AC  = 12;
  localparam int AR  = 6;
  localparam int HFP = 2;
  localparam int HBP = 3;
  localparam int VFP = 1;
  localparam int VBP = 2;
  localparam int VW  = 4;

  // Hand-derived sync windows for the reduced raster
  localparam int HS_LO = 14;
  localparam int HS_HI = 16;
  localparam int VS_LO = 7;
  localparam int VS_HI = 7;

  typedef struct packed {
    logic        chk_sync;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        lk;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_HSync, i_VSync;
  logic [VW-1:0] i_Red, i_Grn, i_Blu;
  logic          o_HSync, o_VSync, o_Locked;
  logic [VW-1:0] o_Red, o_Grn, o_Blu;

  exp_t q[$];
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   idx    = 0;

  vga_sync_porch #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_FRONT_PORCH(HFP), .H_BACK_PORCH(HBP), .V_FRONT_PORCH(VFP),
    .V_BACK_PORCH(VBP), .VIDEO_WIDTH(VW)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_HSync(i_HSync), .i_VSync(i_VSync),
    .i_Red(i_Red), .i_Grn(i_Grn), .i_Blu(i_Blu),
    .o_HSync(o_HSync), .o_VSync(o_VSync),
    .o_Red(o_Red), .o_Grn(o_Grn), .o_Blu(o_Blu),
    .o_Locked(o_Locked)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are valid every cycle, two cycles behind the stimulus
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en && q.size() >= 2) begin
      e = q.pop_front();
      idx++;
      checks++;
      if ({o_Red, o_Grn, o_Blu} !== e.rgb) begin
        errors++;
        $display("FAIL rgb px%0d got %h exp %h", idx, {o_Red, o_Grn, o_Blu}, e.rgb);
      end
      checks++;
      if (o_Locked !== e.lk) begin
        errors++;
        $display("FAIL locked px%0d got %b exp %b", idx, o_Locked, e.lk);
      end
      if (e.chk_sync) begin
        checks++;
        if ({o_HSync, o_VSync} !== {e.hs, e.vs}) begin
          errors++;
          $display("FAIL sync px%0d got hs=%b vs=%b exp hs=%b vs=%b",
                   idx, o_HSync, o_VSync, e.hs, e.vs);
        end
      end
    end
  end

  task automatic drive(input int c, input int r, input logic lk, input logic cs);
    exp_t e;
    logic [3:0] rd, gr, bl;
    @(negedge clk);
    rd = 4'(c);
    gr = 4'(r);
    bl = 4'(c + r + 5);
    i_HSync = (c < AC);
    i_VSync = (r < AR);
    i_Red = rd;
    i_Grn = gr;
    i_Blu = bl;
    e.chk_sync = cs;
    e.hs  = !(c >= HS_LO && c <= HS_HI);
    e.vs  = !(r >= VS_LO && r <= VS_HI);
    e.rgb = (lk && c < AC && r < AR) ? {rd, gr, bl} : 12'h000;
    e.lk  = lk;
    q.push_back(e);
  endtask

  // Stream pixels from (c0,r0) through (c1,r1) inclusive in raster order
  task automatic run(input int c0, input int r0, input int c1, input int r1,
                     input logic lk, input logic cs);
    for (int r = r0; r <= r1; r++) begin
      for (int c = (r == r0 ? c0 : 0); c <= (r == r1 ? c1 : TC - 1); c++)
        drive(c, r, lk, cs);
    end
  endtask

  task automatic chk_reset(input string name);
    checks++;
    if ({o_HSync, o_VSync, o_Red, o_Grn, o_Blu, o_Locked} !== {2'b11, 12'h000, 1'b0}) begin
      errors++;
      $display("FAIL %s got hs=%b vs=%b rgb=%h lk=%b exp hs=1 vs=1 rgb=000 lk=0",
               name, o_HSync, o_VSync, {o_Red, o_Grn, o_Blu}, o_Locked);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    i_HSync = 1'b0; i_VSync = 1'b0;
    i_Red = '0; i_Grn = '0; i_Blu = '0;
    #1 rst_n = 1'b0;
    #1 chk_reset("reset_immediate");
    repeat (3) @(negedge clk);
    chk_reset("reset_held");
    @(posedge clk); #2;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Tail of a frame before any frame start: only blanking/lock checked
    run(0, AR, TC - 1, TR - 1, 1'b0, 1'b0);
    // First FS -> ACQUIRE, second FS -> LOCKED; frame B ends 3 pixels short
    run(0, 0, TC - 1, TR - 1, 1'b0, 1'b1);
    run(0, 0, TC - 4, TR - 1, 1'b1, 1'b1);
    // Early FS drops lock; next correctly spaced FS relocks
    run(0, 0, TC - 1, TR - 1, 1'b0, 1'b1);
    run(0, 0, 4, 3, 1'b1, 1'b1);

    // Reset mid-frame while upstream is inside the active area
    @(posedge clk); #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1 chk_reset("midframe_reset_immediate");
    q.delete();
    repeat (3) @(negedge clk);
    chk_reset("midframe_reset_held");
    @(posedge clk); #2;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Resume with VSync already high: no FS until the next rising edge
    run(5, 3, TC - 1, TR - 1, 1'b0, 1'b0);
    run(0, 0, TC - 1, TR - 1, 1'b0, 1'b1);
    run(0, 0, TC - 1, TR - 1, 1'b1, 1'b1);
    run(0, 0, 2, 0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
